alu4_arb_seq: RTL

//  Shares one 4-bit ALU core between two requesters. Round-robin arbiter + FSM sequencer

---
 rtl/alu4_pkg.sv | 23 ++
 rtl/alu4_core.sv | 56 +++++
 rtl/alu4_arb_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu4_pkg.sv
// Shared constants for the two-requester 4-bit ALU sequencer.
package alu4_pkg;

   localparam int ALU_W = 4;
   localparam int RES_W = 8;

   // Opcodes
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_ENC = 4'd8;

   // Sequencer states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU: op, a, b -> 8-bit result plus carry/overflow/error flags.
module alu4_core
   import alu4_pkg::*;
#(
   parameter logic [RES_W-1:0] ENC_KEY = 8'hAB
) (
   input  logic [3:0]       op,
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   output logic [RES_W-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic             err
);

   logic [ALU_W:0] s5;
   logic [ALU_W:0] d5;

   // Decode the opcode and compute result and flags
   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      err    = 1'b0;
      s5     = {1'b0, a} + {1'b0, b};
      d5     = {1'b0, a} - {1'b0, b};
      case (op)
         OP_ADD: begin
            result = {4'h0, s5[3:0]};
            carry  = s5[4];
            ovf    = (a[3] & b[3] & ~s5[3]) | (~a[3] & ~b[3] & s5[3]);
         end
         OP_SUB: begin
            result = {4'h0, d5[3:0]};
            carry  = ~d5[4];
            ovf    = (a[3] & ~b[3] & ~d5[3]) | (~a[3] & b[3] & d5[3]);
         end
         OP_MUL: result = {4'h0, a} * {4'h0, b};
         OP_DIV: begin
            if (b == '0) begin
               err = 1'b1;
            end else begin
               // Remainder in the high nibble, quotient in the low nibble
               result = {a % b, a / b};
            end
         end
         OP_AND: result = {4'h0, a & b};
         OP_OR:  result = {4'h0, a | b};
         OP_XOR: result = {4'h0, a ^ b};
         OP_NOT: result = {4'h0, ~a};
         OP_ENC: result = {a, b} ^ ENC_KEY;
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu4_arb_seq.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one alu4_core between two requesters.
module alu4_arb_seq
   import alu4_pkg::*;
#(
   parameter int unsigned      MUL_LAT = 2,
   parameter int unsigned      DIV_LAT = 4,
   parameter logic [RES_W-1:0] ENC_KEY = 8'hAB
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [ALU_W-1:0] req0_a,
   input  logic [ALU_W-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [ALU_W-1:0] req1_a,
   input  logic [ALU_W-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [RES_W-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_ovf,
   output logic             rsp_err,
   output logic             busy
);

   localparam int CNT_W = 8;

   logic [1:0]       state_q;
   logic             last_grant_q;
   logic [3:0]       op_q;
   logic [ALU_W-1:0] a_q;
   logic [ALU_W-1:0] b_q;
   logic             id_q;
   logic [CNT_W-1:0] cnt_q;
   logic [RES_W-1:0] result_q;
   logic             carry_q;
   logic             ovf_q;
   logic             err_q;

   logic             grant;
   logic             grant_valid;
   logic             accept;
   logic [3:0]       sel_op;
   logic [ALU_W-1:0] sel_a;
   logic [ALU_W-1:0] sel_b;
   logic [CNT_W-1:0] lat_m1;

   logic [RES_W-1:0] core_result;
   logic             core_carry;
   logic             core_ovf;
   logic             core_err;

   // Round-robin grant: a lone requester wins; on contention the one not served last wins
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = req1_valid;
      end
      req0_ready = (state_q == S_IDLE) && grant_valid && !grant;
      req1_ready = (state_q == S_IDLE) && grant_valid && grant;
      accept     = req0_ready | req1_ready;
      sel_op     = grant ? req1_op : req0_op;
      sel_a      = grant ? req1_a  : req0_a;
      sel_b      = grant ? req1_b  : req0_b;
   end

   // EXEC cycles minus one for the op being accepted
   always_comb begin
      lat_m1 = '0;
      if (sel_op == OP_MUL) begin
         lat_m1 = CNT_W'(MUL_LAT - 1);
      end else if (sel_op == OP_DIV) begin
         lat_m1 = CNT_W'(DIV_LAT - 1);
      end
   end

   alu4_core #(
      .ENC_KEY (ENC_KEY)
   ) u_core (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (core_result),
      .carry  (core_carry),
      .ovf    (core_ovf),
      .err    (core_err)
   );

   // Sequencer state, latched command, latency counter and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         cnt_q        <= '0;
         result_q     <= '0;
         carry_q      <= 1'b0;
         ovf_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q         <= sel_op;
                  a_q          <= sel_a;
                  b_q          <= sel_b;
                  id_q         <= grant;
                  last_grant_q <= grant;
                  cnt_q        <= lat_m1;
                  state_q      <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt_q == '0) begin
                  result_q <= core_result;
                  carry_q  <= core_carry;
                  ovf_q    <= core_ovf;
                  err_q    <= core_err;
                  state_q  <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Response port is driven straight from registered state
   always_comb begin
      rsp_valid  = (state_q == S_RESP);
      busy       = (state_q != S_IDLE);
      rsp_id     = id_q;
      rsp_result = result_q;
      rsp_carry  = carry_q;
      rsp_ovf    = ovf_q;
      rsp_err    = err_q;
   end

endmodule
